snow64_ext_dat_acc_mem_responder: RTL and testbench

Memory-side responder for the Snow64 CPU external data access port (the `ext_dat_acc_mem` channel). It accepts one read or write request at a time, holds `busy` high for a fixed, parameterized latency, and then commits the write or returns 256-bit line data. It models a line-granular memory for simulation and FPGA bring-up. It also keeps saturating read and write counters for bench statistics.

---
 rtl/snow64_ext_dat_acc_mem_responder_if.sv | 34 +++
 rtl/snow64_ext_dat_acc_mem_responder.sv | 109 ++++++++++
 tb/tb_snow64_ext_dat_acc_mem_responder.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snow64_ext_dat_acc_mem_responder_if.sv
// Snow64 external data access channel (ext_dat_acc_mem) between the CPU
// (master) and the memory-side responder (slave).
interface snow64_ext_dat_acc_mem_responder_if;
    logic         in_req;
    logic         in_access_type;
    logic [63:0]  in_addr;
    logic [255:0] in_data;
    logic         out_busy;
    logic [255:0] out_data;
    logic [31:0]  out_num_reads;
    logic [31:0]  out_num_writes;

    modport slave (
        input  in_req,
        input  in_access_type,
        input  in_addr,
        input  in_data,
        output out_busy,
        output out_data,
        output out_num_reads,
        output out_num_writes
    );

    modport master (
        output in_req,
        output in_access_type,
        output in_addr,
        output in_data,
        input  out_busy,
        input  out_data,
        input  out_num_reads,
        input  out_num_writes
    );
endinterface

// File: rtl/snow64_ext_dat_acc_mem_responder.sv
// Line-granular memory responder for the Snow64 external data access port.
// One request at a time: busy for LATENCY cycles, then the captured write is
// committed or the addressed line is returned on out_data. Saturating
// read/write completion counters are kept for bench statistics.
module snow64_ext_dat_acc_mem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 3
) (
    input  logic clk,
    input  logic rst,
    snow64_ext_dat_acc_mem_responder_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Busy lasts LATENCY cycles: the load cycle plus LATENCY-1 decrements.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [0:0]            r_state;
    logic [3:0]            r_cnt;
    logic                  r_is_write;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [255:0]          r_wdata;
    logic [255:0]          r_rdata;
    logic [31:0]           r_num_reads;
    logic [31:0]           r_num_writes;

    // Line storage; deliberately not reset so contents survive rst.
    logic [255:0]          r_mem [0:DEPTH-1];

    logic w_accept;
    logic w_done;
    logic w_commit_wr;
    logic w_commit_rd;

    assign w_accept    = (r_state == ST_IDLE) && bus.in_req;
    assign w_done      = (r_state == ST_BUSY) && (r_cnt == 4'd0);
    // Reset on the completion edge discards the pending operation.
    assign w_commit_wr = w_done && r_is_write && !rst;
    assign w_commit_rd = w_done && !r_is_write;

    // Request capture, latency countdown and IDLE/BUSY sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_is_write <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state    <= ST_BUSY;
                        r_cnt      <= CNT_LOAD;
                        r_is_write <= bus.in_access_type;
                        r_idx      <= bus.in_addr[5+DEPTH_LOG2-1:5];
                        r_wdata    <= bus.in_data;
                    end
                end
                default: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
            endcase
        end
    end

    // Storage write port, committed on the last busy edge of a write.
    always_ff @(posedge clk) begin
        if (w_commit_wr) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    // Registered read port; holds the last read line until the next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_commit_rd) begin
            r_rdata <= r_mem[r_idx];
        end
    end

    // Saturating completion counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_num_reads  <= '0;
            r_num_writes <= '0;
        end else begin
            if (w_commit_rd && (r_num_reads != 32'hFFFF_FFFF)) begin
                r_num_reads <= r_num_reads + 32'd1;
            end
            if (w_commit_wr && (r_num_writes != 32'hFFFF_FFFF)) begin
                r_num_writes <= r_num_writes + 32'd1;
            end
        end
    end

    assign bus.out_busy       = (r_state == ST_BUSY);
    assign bus.out_data       = r_rdata;
    assign bus.out_num_reads  = r_num_reads;
    assign bus.out_num_writes = r_num_writes;
endmodule

// File: tb/tb_snow64_ext_dat_acc_mem_responder.sv
// Bench for snow64_ext_dat_acc_mem_responder: directed scenarios plus a
// randomized sequence, checked against an array-based reference memory.
module tb_snow64_ext_dat_acc_mem_responder;
    localparam int DL  = 8;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    snow64_ext_dat_acc_mem_responder_if bus ();
    snow64_ext_dat_acc_mem_responder_if bus1 ();

    snow64_ext_dat_acc_mem_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    snow64_ext_dat_acc_mem_responder #(.DEPTH_LOG2(DL), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    int total = 0;
    int bad   = 0;

    // Reference model
    logic [255:0] m_mem   [0:(1<<DL)-1];
    bit           m_known [0:(1<<DL)-1];
    logic [255:0] m_rdata;
    bit           m_rknown;
    logic [31:0]  m_reads;
    logic [31:0]  m_writes;

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int line_of(input logic [63:0] a);
        return int'(a[5+DL-1:5]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_rdata  = '0;
        m_rknown = 1'b1;
        m_reads  = 0;
        m_writes = 0;
    endtask

    // One request on the main DUT, issued in the current (idle) cycle.
    // inject > 0 drives a spurious request during that busy cycle.
    task automatic do_req(input bit t, input logic [63:0] a, input logic [255:0] d,
                          input int inject, input string name);
        int bc;
        int ln;
        bus.in_req = 1'b1;
        bus.in_access_type = t;
        bus.in_addr = a;
        bus.in_data = d;
        step();
        bc = 0;
        while (bus.out_busy === 1'b1 && bc < 20) begin
            bc++;
            if (bc == inject) begin
                bus.in_req = 1'b1;
                bus.in_access_type = 1'($urandom);
                bus.in_addr = {$urandom, $urandom};
                bus.in_data = rand256();
            end else begin
                bus.in_req = 1'b0;
            end
            step();
        end
        bus.in_req = 1'b0;
        ln = line_of(a);
        if (t) begin
            m_mem[ln] = d;
            m_known[ln] = 1'b1;
            if (m_writes != 32'hFFFF_FFFF) m_writes++;
        end else begin
            m_rknown = m_known[ln];
            m_rdata  = m_mem[ln];
            if (m_reads != 32'hFFFF_FFFF) m_reads++;
        end
        total++;
        if (bc !== LAT) begin
            bad++;
            $display("FAIL %s busy_cycles got=%0d want=%0d", name, bc, LAT);
        end
        total++;
        if (bus.out_num_reads !== m_reads) begin
            bad++;
            $display("FAIL %s reads got=%h want=%h", name, bus.out_num_reads, m_reads);
        end
        total++;
        if (bus.out_num_writes !== m_writes) begin
            bad++;
            $display("FAIL %s writes got=%h want=%h", name, bus.out_num_writes, m_writes);
        end
        if (m_rknown) begin
            total++;
            if (bus.out_data !== m_rdata) begin
                bad++;
                $display("FAIL %s data got=%h want=%h", name, bus.out_data, m_rdata);
            end
        end
        $display("txn %s %s addr=%h busy=%0d reads=%0d writes=%0d", name,
                 t ? "WR" : "RD", a, bc, bus.out_num_reads, bus.out_num_writes);
    endtask

    task automatic test_reset();
        // Request held high during reset must not be accepted.
        rst = 1'b1;
        bus.in_req = 1'b1;
        bus.in_access_type = 1'b1;
        bus.in_addr = 64'h40;
        bus.in_data = rand256();
        step();
        step();
        rst = 1'b0;
        bus.in_req = 1'b0;
        model_reset();
        total++;
        if (bus.out_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy got=%b want=0", bus.out_busy);
        end
        total++;
        if (bus.out_data !== 256'd0) begin
            bad++;
            $display("FAIL reset_data got=%h want=0", bus.out_data);
        end
        total++;
        if (bus.out_num_reads !== 0 || bus.out_num_writes !== 0) begin
            bad++;
            $display("FAIL reset_counts got=%0d/%0d want=0/0", bus.out_num_reads, bus.out_num_writes);
        end
        step();
        total++;
        if (bus.out_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_req_dropped busy got=%b want=0", bus.out_busy);
        end
        $display("txn reset done");
    endtask

    task automatic test_basic();
        logic [255:0] aa;
        aa = {32{8'hAA}};
        do_req(1'b1, 64'h40, aa, 0, "basic_wr");
        do_req(1'b0, 64'h40, '0, 0, "basic_rd");
        total++;
        if (bus.out_data !== aa) begin
            bad++;
            $display("FAIL basic_aa got=%h want=%h", bus.out_data, aa);
        end
    endtask

    task automatic test_alias();
        logic [255:0] v;
        v = rand256();
        do_req(1'b1, 64'h0000_0000_0000_2020, v, 0, "alias_wr");
        do_req(1'b0, 64'h20, '0, 0, "alias_rd20");
        do_req(1'b0, 64'h3F, '0, 0, "alias_rd3f");
    endtask

    task automatic test_busy_ignore();
        logic [255:0] x;
        x = rand256();
        do_req(1'b1, 64'd5 << 5, x, 0, "ign_wr");
        step();
        // Reads counted fresh from a reset so the "reads=1" target is exact.
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        do_req(1'b1, 64'd6 << 5, rand256(), 2, "ign_wr_inject");
        do_req(1'b0, 64'd5 << 5, '0, 0, "ign_rd");
        total++;
        if (bus.out_data !== x || bus.out_num_reads !== 32'd1) begin
            bad++;
            $display("FAIL ign_result data=%h reads=%0d want data=%h reads=1",
                     bus.out_data, bus.out_num_reads, x);
        end
        step();
        total++;
        if (bus.out_busy !== 1'b0) begin
            bad++;
            $display("FAIL ign_no_queue busy got=%b want=0", bus.out_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] y;
        y = rand256();
        do_req(1'b1, 64'd7 << 5, y, 0, "b2b_wr");
        // Issued in the first idle cycle: exactly one low cycle between windows.
        do_req(1'b0, 64'd7 << 5, '0, 0, "b2b_rd");
        total++;
        if (bus.out_data !== y) begin
            bad++;
            $display("FAIL b2b_data got=%h want=%h", bus.out_data, y);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [255:0] w;
        w = rand256();
        do_req(1'b1, 64'd9 << 5, w, 0, "rstw_w");
        bus.in_req = 1'b1;
        bus.in_access_type = 1'b1;
        bus.in_addr = 64'd9 << 5;
        bus.in_data = rand256();
        step();
        bus.in_req = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        total++;
        if (bus.out_busy !== 1'b0 || bus.out_num_reads !== 0 || bus.out_num_writes !== 0
            || bus.out_data !== 256'd0) begin
            bad++;
            $display("FAIL rstw_state busy=%b reads=%0d writes=%0d data=%h want 0/0/0/0",
                     bus.out_busy, bus.out_num_reads, bus.out_num_writes, bus.out_data);
        end
        step();
        do_req(1'b0, 64'd9 << 5, '0, 0, "rstw_rd");
        total++;
        if (bus.out_data !== w) begin
            bad++;
            $display("FAIL rstw_keep got=%h want=%h", bus.out_data, w);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            bit t;
            logic [63:0] a;
            int inj;
            t = 1'($urandom);
            a = {$urandom, $urandom};
            a[5+DL-1:5] = 8'($urandom_range(0, 15));
            inj = $urandom_range(0, LAT);
            do_req(t, a, rand256(), inj, "rand");
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
        end
    endtask

    task automatic test_saturation();
        force dut.r_num_reads = 32'hFFFF_FFFE;
        step();
        release dut.r_num_reads;
        m_reads = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) do_req(1'b0, 64'd7 << 5, '0, 0, "sat_rd");
        total++;
        if (bus.out_num_reads !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL sat_hold got=%h want=ffffffff", bus.out_num_reads);
        end
    endtask

    task automatic test_latency1();
        logic [255:0] v;
        v = rand256();
        bus1.in_req = 1'b1;
        bus1.in_access_type = 1'b1;
        bus1.in_addr = 64'h1A0;
        bus1.in_data = v;
        step();
        bus1.in_req = 1'b0;
        total++;
        if (bus1.out_busy !== 1'b1) begin
            bad++;
            $display("FAIL lat1_wr_busy got=%b want=1", bus1.out_busy);
        end
        step();
        total++;
        if (bus1.out_busy !== 1'b0 || bus1.out_num_writes !== 32'd1) begin
            bad++;
            $display("FAIL lat1_wr_done busy=%b writes=%0d want 0/1", bus1.out_busy, bus1.out_num_writes);
        end
        bus1.in_req = 1'b1;
        bus1.in_access_type = 1'b0;
        step();
        bus1.in_req = 1'b0;
        total++;
        if (bus1.out_busy !== 1'b1) begin
            bad++;
            $display("FAIL lat1_rd_busy got=%b want=1", bus1.out_busy);
        end
        step();
        total++;
        if (bus1.out_busy !== 1'b0 || bus1.out_data !== v || bus1.out_num_reads !== 32'd1) begin
            bad++;
            $display("FAIL lat1_rd_done busy=%b reads=%0d data=%h want 0/1/%h",
                     bus1.out_busy, bus1.out_num_reads, bus1.out_data, v);
        end
        $display("txn lat1 wr+rd addr=1a0 reads=%0d writes=%0d", bus1.out_num_reads, bus1.out_num_writes);
    endtask

    initial begin
        for (int i = 0; i < (1 << DL); i++) begin
            m_known[i] = 1'b0;
            m_mem[i] = '0;
        end
        model_reset();
        bus.in_req = 1'b0;
        bus.in_access_type = 1'b0;
        bus.in_addr = '0;
        bus.in_data = '0;
        bus1.in_req = 1'b0;
        bus1.in_access_type = 1'b0;
        bus1.in_addr = '0;
        bus1.in_data = '0;
        test_reset();
        test_basic();
        test_alias();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_write();
        test_random();
        test_saturation();
        test_latency1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
